// File: rtl/obstacle_pkg.sv
// Shared types, constants and the speed-class step function for the obstacle pool,
// renderer and collision logic.
package obstacle_pkg;

   localparam int COORD_W = 10;
   localparam int TYPE_W  = 2;

   localparam int DEF_SCREEN_W  = 640;
   localparam int DEF_SCREEN_H  = 480;
   localparam int DEF_OBST_W    = 32;
   localparam int DEF_OBST_H    = 32;
   localparam int DEF_START_Y   = 0;
   localparam int DEF_BASE_STEP = 4;

   typedef logic [TYPE_W-1:0] obst_type_t;

   // Pixels per tick for a speed class; one bit wider than a coordinate.
   function automatic logic [COORD_W:0] step_for(input obst_type_t t, input int base_step);
      return (COORD_W+1)'(base_step * (int'(t) + 1));
   endfunction

endpackage

// File: rtl/obstacle_slot.sv
// One obstacle slot: holds active/x/y/type, loads on spawn, falls on tick and
// retires once it passes the bottom of the playfield.
module obstacle_slot
   import obstacle_pkg::*;
#(
   parameter int SCREEN_W  = DEF_SCREEN_W,
   parameter int SCREEN_H  = DEF_SCREEN_H,
   parameter int OBST_W    = DEF_OBST_W,
   parameter int OBST_H    = DEF_OBST_H,
   parameter int START_Y   = DEF_START_Y,
   parameter int BASE_STEP = DEF_BASE_STEP
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               clear_i,
   input  logic               tick_i,
   input  logic               load_i,
   input  logic [COORD_W-1:0] load_x_i,
   input  obst_type_t         load_type_i,
   output logic               active_o,
   output logic [COORD_W-1:0] x_o,
   output logic [COORD_W-1:0] y_o,
   output obst_type_t         type_o,
   output logic               retire_o
);

   localparam logic [COORD_W:0]   Y_LIMIT = (COORD_W+1)'(SCREEN_H - OBST_H);
   localparam logic [COORD_W-1:0] X_MAX   = COORD_W'(SCREEN_W - OBST_W);
   localparam logic [COORD_W-1:0] Y_START = COORD_W'(START_Y);

   logic               active_q, active_d;
   logic [COORD_W-1:0] x_q, x_d;
   logic [COORD_W-1:0] y_q, y_d;
   obst_type_t         type_q, type_d;
   logic [COORD_W:0]   ny;
   logic               retire;

   // Extra bit keeps y + step from wrapping before the limit compare.
   assign ny     = {1'b0, y_q} + step_for(type_q, BASE_STEP);
   assign retire = tick_i & active_q & (ny > Y_LIMIT);

   always_comb begin
      active_d = active_q;
      x_d      = x_q;
      y_d      = y_q;
      type_d   = type_q;
      if (clear_i) begin
         active_d = 1'b0;
      end else begin
         if (tick_i && active_q) begin
            if (retire) active_d = 1'b0;
            else        y_d      = ny[COORD_W-1:0];
         end
         // The top only loads a slot that was free at the start of the cycle.
         if (load_i) begin
            active_d = 1'b1;
            x_d      = (load_x_i > X_MAX) ? X_MAX : load_x_i;
            y_d      = Y_START;
            type_d   = load_type_i;
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         active_q <= 1'b0;
         x_q      <= '0;
         y_q      <= '0;
         type_q   <= '0;
      end else begin
         active_q <= active_d;
         x_q      <= x_d;
         y_q      <= y_d;
         type_q   <= type_d;
      end
   end

   assign active_o = active_q;
   assign x_o      = x_q;
   assign y_o      = y_q;
   assign type_o   = type_q;
   assign retire_o = retire;

endmodule

// File: rtl/obstacle_pool.sv
// Pool of falling obstacles: lowest-free slot allocation for spawns, per-tick
// movement in the slots, and a count of obstacles retired off the bottom.
module obstacle_pool
   import obstacle_pkg::*;
#(
   parameter int N_SLOTS   = 4,
   parameter int SCREEN_W  = DEF_SCREEN_W,
   parameter int SCREEN_H  = DEF_SCREEN_H,
   parameter int OBST_W    = DEF_OBST_W,
   parameter int OBST_H    = DEF_OBST_H,
   parameter int START_Y   = DEF_START_Y,
   parameter int BASE_STEP = DEF_BASE_STEP
) (
   input  logic                       CLOCK_50,
   input  logic                       reset,
   input  logic                       clear,
   input  logic                       frame_tick,
   input  logic                       pause,
   input  logic                       spawn_valid,
   input  logic [COORD_W-1:0]         spawn_x,
   input  logic [TYPE_W-1:0]          spawn_type,
   output logic                       spawn_ack,
   output logic [3:0]                 spawn_slot,
   output logic                       spawn_drop,
   output logic [N_SLOTS-1:0]         obs_active,
   output logic [COORD_W*N_SLOTS-1:0] obs_x,
   output logic [COORD_W*N_SLOTS-1:0] obs_y,
   output logic [TYPE_W*N_SLOTS-1:0]  obs_type,
   output logic [15:0]                passed_count
);

   logic               tick;
   logic               spawn_req;
   logic               free_found;
   logic [3:0]         free_idx;
   logic [N_SLOTS-1:0] load_vec;
   logic [N_SLOTS-1:0] retire_vec;
   logic [4:0]         retire_cnt;

   logic        ack_q, ack_d;
   logic        drop_q, drop_d;
   logic [3:0]  slot_q, slot_d;
   logic [15:0] passed_q, passed_d;

   assign tick      = frame_tick & ~pause & ~clear;
   assign spawn_req = spawn_valid & ~clear;

   // Lowest-index free slot, taken from registered active flags only.
   always_comb begin
      free_found = 1'b0;
      free_idx   = '0;
      load_vec   = '0;
      for (int i = 0; i < N_SLOTS; i++) begin
         if (!obs_active[i] && !free_found) begin
            free_found  = 1'b1;
            free_idx    = 4'(i);
            load_vec[i] = spawn_req;
         end
      end
   end

   always_comb begin
      retire_cnt = '0;
      for (int i = 0; i < N_SLOTS; i++) begin
         retire_cnt = retire_cnt + 5'(retire_vec[i]);
      end
   end

   always_comb begin
      ack_d    = spawn_req & free_found;
      drop_d   = spawn_req & ~free_found;
      slot_d   = (spawn_req && free_found) ? free_idx : slot_q;
      passed_d = clear ? 16'd0 : passed_q + 16'(retire_cnt);
   end

   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         ack_q    <= 1'b0;
         drop_q   <= 1'b0;
         slot_q   <= '0;
         passed_q <= '0;
      end else begin
         ack_q    <= ack_d;
         drop_q   <= drop_d;
         slot_q   <= slot_d;
         passed_q <= passed_d;
      end
   end

   for (genvar g = 0; g < N_SLOTS; g++) begin : g_slot
      obstacle_slot #(
         .SCREEN_W  (SCREEN_W),
         .SCREEN_H  (SCREEN_H),
         .OBST_W    (OBST_W),
         .OBST_H    (OBST_H),
         .START_Y   (START_Y),
         .BASE_STEP (BASE_STEP)
      ) u_slot (
         .clk_i       (CLOCK_50),
         .rst_i       (reset),
         .clear_i     (clear),
         .tick_i      (tick),
         .load_i      (load_vec[g]),
         .load_x_i    (spawn_x),
         .load_type_i (spawn_type),
         .active_o    (obs_active[g]),
         .x_o         (obs_x[COORD_W*g +: COORD_W]),
         .y_o         (obs_y[COORD_W*g +: COORD_W]),
         .type_o      (obs_type[TYPE_W*g +: TYPE_W]),
         .retire_o    (retire_vec[g])
      );
   end

   assign spawn_ack    = ack_q;
   assign spawn_drop   = drop_q;
   assign spawn_slot   = slot_q;
   assign passed_count = passed_q;

endmodule

// File: tb/tb_obstacle_pool.sv
// Directed bench for obstacle_pool at default parameters (4 slots, 640x480, 32x32, step 4).
module tb_obstacle_pool;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        clear = 1'b0;
   logic        frame_tick = 1'b0;
   logic        pause = 1'b0;
   logic        spawn_valid = 1'b0;
   logic [9:0]  spawn_x = '0;
   logic [1:0]  spawn_type = '0;
   logic        spawn_ack;
   logic [3:0]  spawn_slot;
   logic        spawn_drop;
   logic [3:0]  obs_active;
   logic [39:0] obs_x;
   logic [39:0] obs_y;
   logic [7:0]  obs_type;
   logic [15:0] passed_count;

   int n_tests = 0;
   int n_fail  = 0;

   obstacle_pool dut (
      .CLOCK_50     (clk),
      .reset        (reset),
      .clear        (clear),
      .frame_tick   (frame_tick),
      .pause        (pause),
      .spawn_valid  (spawn_valid),
      .spawn_x      (spawn_x),
      .spawn_type   (spawn_type),
      .spawn_ack    (spawn_ack),
      .spawn_slot   (spawn_slot),
      .spawn_drop   (spawn_drop),
      .obs_active   (obs_active),
      .obs_x        (obs_x),
      .obs_y        (obs_y),
      .obs_type     (obs_type),
      .passed_count (passed_count)
   );

   always #5 clk = ~clk;

   function automatic logic [9:0] fx(input int i);
      return obs_x[10*i +: 10];
   endfunction
   function automatic logic [9:0] fy(input int i);
      return obs_y[10*i +: 10];
   endfunction
   function automatic logic [1:0] ft(input int i);
      return obs_type[2*i +: 2];
   endfunction

   // Inputs change and outputs are sampled 1 time unit after each rising edge.
   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1;
      reset = 1'b1;
      #3;
      reset = 1'b0;
   endtask

   task automatic spawn(input logic [9:0] x, input logic [1:0] t);
      spawn_valid = 1'b1;
      spawn_x     = x;
      spawn_type  = t;
      cycle();
      spawn_valid = 1'b0;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) begin
         frame_tick = 1'b1;
         cycle();
         frame_tick = 1'b0;
      end
   endtask

   task automatic test_reset();
      do_reset();
      n_tests++; if (obs_active !== 4'h0) begin n_fail++; $display("FAIL reset_active got %h want 0", obs_active); end
      n_tests++; if (obs_x !== 40'h0 || obs_y !== 40'h0 || obs_type !== 8'h0) begin n_fail++; $display("FAIL reset_fields got x=%h y=%h t=%h want 0", obs_x, obs_y, obs_type); end
      n_tests++; if (spawn_ack !== 1'b0 || spawn_drop !== 1'b0 || spawn_slot !== 4'd0) begin n_fail++; $display("FAIL reset_spawn got ack=%b drop=%b slot=%0d want 0", spawn_ack, spawn_drop, spawn_slot); end
      n_tests++; if (passed_count !== 16'd0) begin n_fail++; $display("FAIL reset_count got %0d want 0", passed_count); end
   endtask

   task automatic test_spawn();
      do_reset();
      spawn(10'd100, 2'd0);
      n_tests++; if (spawn_ack !== 1'b1 || spawn_drop !== 1'b0 || spawn_slot !== 4'd0) begin n_fail++; $display("FAIL spawn_ack got ack=%b drop=%b slot=%0d want 1 0 0", spawn_ack, spawn_drop, spawn_slot); end
      n_tests++; if (obs_active !== 4'b0001 || fx(0) !== 10'd100 || fy(0) !== 10'd0) begin n_fail++; $display("FAIL spawn_slot0 got act=%b x=%0d y=%0d want 0001 100 0", obs_active, fx(0), fy(0)); end
      cycle();
      n_tests++; if (spawn_ack !== 1'b0) begin n_fail++; $display("FAIL spawn_ack_pulse got %b want 0", spawn_ack); end
      ticks(3);
      n_tests++; if (fy(0) !== 10'd12 || obs_active !== 4'b0001) begin n_fail++; $display("FAIL spawn_3ticks got y=%0d act=%b want 12 0001", fy(0), obs_active); end
   endtask

   task automatic test_clamp();
      do_reset();
      spawn(10'd700, 2'd3);
      n_tests++; if (fx(0) !== 10'd608 || ft(0) !== 2'd3) begin n_fail++; $display("FAIL clamp_x got x=%0d t=%0d want 608 3", fx(0), ft(0)); end
      ticks(1);
      n_tests++; if (fy(0) !== 10'd16) begin n_fail++; $display("FAIL type3_step got %0d want 16", fy(0)); end
   endtask

   task automatic test_full();
      do_reset();
      spawn_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         spawn_x = 10'(10 * (i + 1));
         cycle();
         if (i < 4) begin
            n_tests++; if (spawn_ack !== 1'b1 || spawn_drop !== 1'b0 || spawn_slot !== 4'(i)) begin n_fail++; $display("FAIL full_ack%0d got ack=%b drop=%b slot=%0d want 1 0 %0d", i, spawn_ack, spawn_drop, spawn_slot, i); end
         end else begin
            n_tests++; if (spawn_ack !== 1'b0 || spawn_drop !== 1'b1 || spawn_slot !== 4'd3) begin n_fail++; $display("FAIL full_drop got ack=%b drop=%b slot=%0d want 0 1 3", spawn_ack, spawn_drop, spawn_slot); end
         end
      end
      spawn_valid = 1'b0;
      n_tests++; if (obs_active !== 4'hF || fx(0) !== 10'd10 || fx(3) !== 10'd40) begin n_fail++; $display("FAIL full_state got act=%b x0=%0d x3=%0d want 1111 10 40", obs_active, fx(0), fx(3)); end
   endtask

   task automatic test_retire();
      do_reset();
      spawn(10'd0, 2'd0);
      ticks(56);
      spawn(10'd64, 2'd1);
      ticks(55);
      n_tests++; if (fy(0) !== 10'd444 || fy(1) !== 10'd440 || passed_count !== 16'd0) begin n_fail++; $display("FAIL retire_setup got y0=%0d y1=%0d cnt=%0d want 444 440 0", fy(0), fy(1), passed_count); end
      ticks(1);
      n_tests++; if (obs_active !== 4'b0011 || fy(0) !== 10'd448 || fy(1) !== 10'd448) begin n_fail++; $display("FAIL retire_edge got act=%b y0=%0d y1=%0d want 0011 448 448", obs_active, fy(0), fy(1)); end
      ticks(1);
      n_tests++; if (obs_active !== 4'b0000 || passed_count !== 16'd2) begin n_fail++; $display("FAIL retire_both got act=%b cnt=%0d want 0000 2", obs_active, passed_count); end
      n_tests++; if (fy(0) !== 10'd448 || fx(1) !== 10'd64 || ft(1) !== 2'd1) begin n_fail++; $display("FAIL retire_stale got y0=%0d x1=%0d t1=%0d want 448 64 1", fy(0), fx(1), ft(1)); end
   endtask

   task automatic test_back_to_back();
      do_reset();
      spawn(10'd0, 2'd0);
      spawn(10'd50, 2'd0);
      spawn(10'd100, 2'd3);
      spawn(10'd150, 2'd0);
      ticks(28);
      n_tests++; if (obs_active !== 4'hF || fy(2) !== 10'd448 || fy(0) !== 10'd112) begin n_fail++; $display("FAIL simul_setup got act=%b y2=%0d y0=%0d want 1111 448 112", obs_active, fy(2), fy(0)); end
      spawn_valid = 1'b1; spawn_x = 10'd300; spawn_type = 2'd1; frame_tick = 1'b1;
      cycle();
      frame_tick = 1'b0;
      n_tests++; if (spawn_drop !== 1'b1 || spawn_ack !== 1'b0 || obs_active !== 4'b1011 || passed_count !== 16'd1) begin n_fail++; $display("FAIL simul_drop got drop=%b ack=%b act=%b cnt=%0d want 1 0 1011 1", spawn_drop, spawn_ack, obs_active, passed_count); end
      cycle();
      spawn_valid = 1'b0;
      n_tests++; if (spawn_ack !== 1'b1 || spawn_slot !== 4'd2 || fy(2) !== 10'd0 || fx(2) !== 10'd300 || obs_active !== 4'hF) begin n_fail++; $display("FAIL simul_refill got ack=%b slot=%0d y2=%0d x2=%0d act=%b want 1 2 0 300 1111", spawn_ack, spawn_slot, fy(2), fx(2), obs_active); end
      do_reset();
      spawn(10'd20, 2'd0);
      ticks(1);
      spawn_valid = 1'b1; spawn_x = 10'd40; spawn_type = 2'd2; frame_tick = 1'b1;
      cycle();
      spawn_valid = 1'b0; frame_tick = 1'b0;
      n_tests++; if (spawn_ack !== 1'b1 || spawn_slot !== 4'd1 || fy(1) !== 10'd0 || fy(0) !== 10'd8) begin n_fail++; $display("FAIL spawn_with_tick got ack=%b slot=%0d y1=%0d y0=%0d want 1 1 0 8", spawn_ack, spawn_slot, fy(1), fy(0)); end
   endtask

   task automatic test_pause_clear();
      do_reset();
      spawn(10'd0, 2'd3);
      ticks(29);
      n_tests++; if (passed_count !== 16'd1 || obs_active !== 4'h0) begin n_fail++; $display("FAIL pc_setup got cnt=%0d act=%b want 1 0000", passed_count, obs_active); end
      spawn(10'd5, 2'd0);
      pause = 1'b1;
      for (int i = 0; i < 10; i++) begin
         frame_tick  = 1'b1;
         spawn_valid = (i == 5);
         spawn_x     = 10'd200;
         cycle();
         if (i == 5) begin
            n_tests++; if (spawn_ack !== 1'b1 || spawn_slot !== 4'd1) begin n_fail++; $display("FAIL pause_spawn got ack=%b slot=%0d want 1 1", spawn_ack, spawn_slot); end
         end
      end
      frame_tick = 1'b0; spawn_valid = 1'b0; pause = 1'b0;
      n_tests++; if (fy(0) !== 10'd0 || fy(1) !== 10'd0 || obs_active !== 4'b0011) begin n_fail++; $display("FAIL pause_hold got y0=%0d y1=%0d act=%b want 0 0 0011", fy(0), fy(1), obs_active); end
      clear = 1'b1; spawn_valid = 1'b1; frame_tick = 1'b1;
      cycle();
      clear = 1'b0; spawn_valid = 1'b0; frame_tick = 1'b0;
      n_tests++; if (obs_active !== 4'h0 || passed_count !== 16'd0 || spawn_ack !== 1'b0 || spawn_drop !== 1'b0) begin n_fail++; $display("FAIL clear got act=%b cnt=%0d ack=%b drop=%b want 0000 0 0 0", obs_active, passed_count, spawn_ack, spawn_drop); end
      n_tests++; if (spawn_slot !== 4'd1 || fx(1) !== 10'd200 || fy(0) !== 10'd0) begin n_fail++; $display("FAIL clear_keep got slot=%0d x1=%0d y0=%0d want 1 200 0", spawn_slot, fx(1), fy(0)); end
   endtask

   task automatic test_reset_mid();
      do_reset();
      spawn(10'd55, 2'd1);
      ticks(1);
      spawn(10'd66, 2'd2);
      #2;
      reset = 1'b1;
      #1;
      n_tests++; if (spawn_ack !== 1'b0 || obs_active !== 4'h0 || spawn_slot !== 4'd0) begin n_fail++; $display("FAIL reset_mid_ctl got ack=%b act=%b slot=%0d want 0 0000 0", spawn_ack, obs_active, spawn_slot); end
      n_tests++; if (obs_x !== 40'h0 || obs_y !== 40'h0 || obs_type !== 8'h0) begin n_fail++; $display("FAIL reset_mid_fields got x=%h y=%h t=%h want 0", obs_x, obs_y, obs_type); end
      reset = 1'b0;
      spawn(10'd77, 2'd0);
      n_tests++; if (spawn_ack !== 1'b1 || spawn_slot !== 4'd0 || fx(0) !== 10'd77 || obs_active !== 4'b0001) begin n_fail++; $display("FAIL reset_mid_after got ack=%b slot=%0d x0=%0d act=%b want 1 0 77 0001", spawn_ack, spawn_slot, fx(0), obs_active); end
   endtask

   initial begin
      test_reset();
      test_spawn();
      test_clamp();
      test_full();
      test_retire();
      test_back_to_back();
      test_pause_clear();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
